seg7_clock_scan: RTL

//  Parametrised 24/12-hour digital clock with multiplexed common-segment 7-seg display driver.
//  - Derives a 1 Hz tick from sys_clk and keeps BCD time HH:MM:SS.
//  - Supports user time-set pulses.
//  - Scans N_DIGITS digits at SCAN_HZ each, with configurable segment/digit polarity.
//  - Top-level display block on the Tang Nano 9K board; drives the digit pins and segments A-G directly.

---
 rtl/dclk_pkg.sv | 36 +++
 rtl/bcd_mod_counter.sv | 46 ++++
 rtl/seg7_clock_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dclk_pkg.sv
// Shared definitions for the scanned 7-segment clock: BCD digit type,
// segment patterns ({G,F,E,D,C,B,A}, active-high) and the digit decoder.
package dclk_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10-15 never occur in a healthy counter; show them as blank.
  function automatic logic [6:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping after MAX_TENS:MAX_UNITS; carry is a
// combinational look-ahead so downstream counters ripple in the same cycle.
module bcd_mod_counter
  import dclk_pkg::*;
#(
  parameter bcd_t MAX_TENS  = 4'd5,
  parameter bcd_t MAX_UNITS = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t units,
  output logic carry
);

  logic at_max;

  assign at_max = (tens == MAX_TENS) && (units == MAX_UNITS);
  // A clear overrides the increment, so it must also swallow the carry.
  assign carry  = inc && !clr && at_max;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= '0;
      units <= '0;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= '0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/seg7_clock_scan.sv
// 24/12-hour BCD clock with multiplexed 7-segment scan driver.
// Define DCLK_LZ_BLANK_EN to blank a leading zero on the hr-tens digit.
module seg7_clock_scan #(
  parameter int CLK_HZ         = 27_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int N_DIGITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                mode_12h,
  input  logic                inc_min,
  input  logic                inc_hr,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] dig_sel,
  output logic                sec_tick,
  output logic                pm
);
  import dclk_pkg::*;

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW       = $clog2(CLK_HZ + 1);
  localparam int SW       = $clog2(SCAN_DIV + 1);
  localparam int IW       = $clog2(N_DIGITS);
  // 4-digit builds skip the two seconds digits of the six-digit order.
  localparam int OFS      = (N_DIGITS == 6) ? 0 : 2;

  if (!(N_DIGITS == 4 || N_DIGITS == 6)) begin : g_bad_n_digits
    $error("seg7_clock_scan: N_DIGITS must be 4 or 6");
  end

  logic [PW-1:0]       presc;
  logic                tick;
  logic                sec_carry, min_carry;
  bcd_t                sec_t, sec_u, min_t, min_u, hr_t, hr_u;
  logic [4:0]          hr_bin, disp_hr;
  bcd_t                disp_t, disp_u;
  logic [SW-1:0]       scan_cnt;
  logic                wrap;
  logic [IW-1:0]       idx, idx_next;
  logic [2:0]          sel;
  bcd_t                digit;
  logic                blank, colon;
  logic [6:0]          seg_nxt, seg_r;
  logic                dp_nxt, dp_r;
  logic [N_DIGITS-1:0] dig_r;

  assign tick = (presc == PW'(CLK_HZ - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
      presc    <= (inc_min || tick) ? '0 : presc + PW'(1);
    end
  end

  // Setting the minute restarts the second and suppresses any pending carry.
  bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9)) u_sec (
    .clk(sys_clk), .rst_n(sys_rst_n), .inc(tick), .clr(inc_min),
    .tens(sec_t), .units(sec_u), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9)) u_min (
    .clk(sys_clk), .rst_n(sys_rst_n), .inc(inc_min || sec_carry), .clr(1'b0),
    .tens(min_t), .units(min_u), .carry(min_carry)
  );

  bcd_mod_counter #(.MAX_TENS(4'd2), .MAX_UNITS(4'd3)) u_hr (
    .clk(sys_clk), .rst_n(sys_rst_n), .inc(inc_hr || (min_carry && !inc_min)),
    .clr(1'b0), .tens(hr_t), .units(hr_u), .carry()
  );

  assign hr_bin = 5'(hr_t) * 5'd10 + 5'(hr_u);
  assign pm     = (hr_bin >= 5'd12);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    disp_hr = hr_bin;
    if (mode_12h) begin
      if (hr_bin == 5'd0)       disp_hr = 5'd12;
      else if (hr_bin > 5'd12)  disp_hr = hr_bin - 5'd12;
    end
    disp_t = 4'd0;
    disp_u = 4'(disp_hr);
    if (disp_hr >= 5'd20) begin
      disp_t = 4'd2;
      disp_u = 4'(disp_hr - 5'd20);
    end else if (disp_hr >= 5'd10) begin
      disp_t = 4'd1;
      disp_u = 4'(disp_hr - 5'd10);
    end
  end

  assign wrap     = (scan_cnt == SW'(SCAN_DIV - 1));
  assign idx_next = !wrap ? idx : (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
  assign sel      = 3'(idx_next) + 3'(OFS);

  // Segment data is looked up for the slot about to be shown so it settles
  // one cycle before that digit's enable returns.
  always_comb begin
    digit = '0;
    blank = 1'b0;
    colon = 1'b0;
    case (sel)
      3'd0:    digit = sec_u;
      3'd1:    digit = sec_t;
      3'd2:    begin digit = min_u;  colon = (N_DIGITS == 6); end
      3'd3:    digit = min_t;
      3'd4:    begin digit = disp_u; colon = 1'b1; end
      3'd5:    begin
                 digit = disp_t;
`ifdef DCLK_LZ_BLANK_EN
                 blank = (disp_t == 4'd0);
`else
                 blank = 1'b0;
`endif
               end
      default: digit = '0;
    endcase
    seg_nxt = blank ? SEG_BLANK : seg_decode(digit);
    dp_nxt  = colon && (presc < PW'(CLK_HZ / 2));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_r    <= '0;
      dp_r     <= 1'b0;
      dig_r    <= '0;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + SW'(1);
      idx      <= idx_next;
      seg_r    <= seg_nxt;
      dp_r     <= dp_nxt;
      dig_r    <= wrap ? '0 : ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
    end
  end

  assign seg     = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign dp      = dp_r ^ SEG_ACTIVE_LOW;
  assign dig_sel = dig_r ^ {N_DIGITS{DIG_ACTIVE_LOW}};

endmodule
